xgmii_frame_gen: RTL
====================

# xgmii_frame_gen

Parametrised successor to the fixed 64-bit MII frame generator. It emits complete XGMII-style frames with a variable, clamped payload length, on a 32- or 64-bit lane-parallel data/control bus. Each frame carries a START/preamble/SFD header, a payload with a selectable fill pattern, and a TERMINATE in the correct lane, followed by a programmable inter-packet gap (IPG). It sits upstream of the PCS encoder and is used as traffic source and DUT stimulus.

## Interface
- DATA_WIDTH, 64: bus width; legal values are 32 and 64. LANES = DATA_WIDTH/8.
- CTRL_WIDTH, DATA_WIDTH/8: one control bit per lane.
- MIN_LEN, 64: minimum payload bytes; shorter requests are clamped up.
- MAX_LEN, 1518: maximum payload bytes; longer requests are clamped down.
- LEN_WIDTH, 16: width of the length input.
- clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_start  input  1  frame request; level-sampled.
- i_payload_len  input  LEN_WIDTH  payload byte count, sampled on accept.
- i_ipg  input  8  minimum idle bytes between frames, sampled on accept.
- i_fill_mode  input  1  0 = constant i_fill_byte; 1 = incrementing byte.
- i_fill_byte  input  8  constant fill value, sampled on accept.
- o_tx_data  output  DATA_WIDTH  lane i occupies bits [8i+7:8i]; lane 0 is transmitted first.
- o_tx_ctrl  output  CTRL_WIDTH  bit i = 1 means lane i holds a control code.
- o_busy  output  1  high while a frame or its IPG is in progress.
- o_done  output  1  one-cycle pulse coinciding with the word that carries TERMINATE.

## Operation
- Codes: IDLE 0x07, START 0xFB, TERMINATE 0xFD, ERROR 0xFE, PREAMBLE 0x55, SFD 0xD5.
- Header is 8 bytes: START (ctrl=1), six PREAMBLE bytes, then SFD (ctrl=0). It occupies 8/LANES words, and START is always in lane 0.
- Length handling: L = clamp(i_payload_len, MIN_LEN, MAX_LEN).
- Constant fill: every payload byte equals i_fill_byte.
- Incrementing fill: payload bytes run 0x00, 0x01, …; the value restarts at 0x00 each frame and wraps 0xFF→0x00.
- States:
  - IDLE: drives all-IDLE. Moves to PREAMBLE when i_start=1.
  - PREAMBLE: emits the header words, then moves to PAYLOAD.
  - PAYLOAD: emits min(LANES, remaining) payload bytes per word.
    - If remaining < LANES: the word ends the frame. Lane `remaining` carries TERMINATE, higher lanes carry IDLE, and those lanes are ctrl=1. Next state is IPG or IDLE.
    - If remaining hits exactly 0 on a full word: next state is TERM.
  - TERM: emits lane0 = TERMINATE and the other lanes IDLE, with ctrl all ones.
  - IPG: emits all-IDLE words.
- IPG accounting: the idle counter is seeded with the number of IDLE lanes in the terminate word and adds LANES per IPG word. The generator returns to IDLE when counter ≥ sampled i_ipg. If the terminate word alone satisfies the gap, IPG is skipped.
- i_start is ignored whenever the state is not IDLE; requests are not queued. Holding i_start high produces back-to-back frames at the minimum gap.
- Length arithmetic uses LEN_WIDTH-bit unsigned values. The remaining-byte counter never underflows.

## Timing
- All outputs are registered.
- Start latency: if i_start=1 is sampled in IDLE at edge N, the first header word is on o_tx_data from edge N onward.
- o_busy rises at edge N and falls at the edge where the state returns to IDLE.
- Reset values:
  - o_tx_data = all lanes 0x07; o_tx_ctrl = all ones.
  - o_busy = 0; o_done = 0.
  - State IDLE; all counters 0.
  - Gap is considered satisfied, so a frame can start on the first edge after reset release.
- Reset mid-frame aborts immediately to reset values. No TERMINATE is emitted.
- o_done is high for exactly one cycle per frame.

## Configuration
- FRAME_GEN_ERR_INJECT_EN defined: adds port i_err_inject (input, 1 bit).
  - When i_err_inject is high during a PAYLOAD word, every payload lane of that word becomes ERROR 0xFE with ctrl=1.
  - Lane positions, TERMINATE placement and byte counts are unchanged.
  - The incrementing fill value still advances.
- Macro undefined: the port is absent and no error codes are ever produced.

## Structure
- Package xgmii_gen_pkg holds:
  - state_t enum (IDLE, PREAMBLE, PAYLOAD, TERM, IPG);
  - the code constants listed under Operation;
  - the header byte constants.
- Sub-module xgmii_payload_src produces LANES payload bytes per cycle for the selected fill mode, with a per-frame restart input and an advance input.

## Test plan
- 64-bit, L=64, fill constant 0xAA, ipg=12:
  - header word 0xD5555555555555FB, ctrl 0x01;
  - 8 words of 0xAA…, ctrl 0x00;
  - TERM word 0x07070707070707FD, ctrl 0xFF, with o_done;
  - one IPG word, then IDLE.
- 64-bit, L=65:
  - 9th payload word = 0x070707070707FDAA, ctrl 0xFE;
  - 6 idle lanes counted, so one IPG word follows.
- i_payload_len=10 with incrementing fill: clamped to 64, payload bytes 0x00..0x3F in order.
- i_start held high, ipg=0, L=64: second START appears on the word immediately after the TERM word.
- i_rst asserted at the 3rd payload word:
  - next edge shows o_tx_data=0x0707070707070707, ctrl 0xFF, o_busy=0;
  - a new frame starts normally afterwards.
- DATA_WIDTH=32 with FRAME_GEN_ERR_INJECT_EN, i_err_inject pulsed on payload word 2:
  - header words 0x555555FB/ctrl 0x1 and 0xD5555555/ctrl 0x0;
  - the injected word is 0xFEFEFEFE with ctrl 0xF.

Source files
------------

// File: rtl/xgmii_gen_pkg.sv
// Shared XGMII codes, header bytes and FSM state type for the frame generator.
package xgmii_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    TERM,
    IPG
  } state_t;

  localparam logic [7:0] C_IDLE     = 8'h07;
  localparam logic [7:0] C_START    = 8'hFB;
  localparam logic [7:0] C_TERM     = 8'hFD;
  localparam logic [7:0] C_ERROR    = 8'hFE;
  localparam logic [7:0] C_PREAMBLE = 8'h55;
  localparam logic [7:0] C_SFD      = 8'hD5;

  // Header in transmit order, lane 0 (START) in the low byte.
  localparam logic [63:0] HDR_DATA = {C_SFD, {6{C_PREAMBLE}}, C_START};
  localparam logic [7:0]  HDR_CTRL = 8'h01;

endpackage

// File: rtl/xgmii_payload_src.sv
// Payload byte source: LANES bytes per cycle, constant or incrementing fill.
module xgmii_payload_src #(
  parameter int LANES = 8
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               restart_i,
  input  logic               advance_i,
  input  logic               fill_mode_i,
  input  logic [7:0]         fill_byte_i,
  output logic [8*LANES-1:0] bytes_o
);

  logic       mode_q;
  logic [7:0] fill_q;
  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q <= 1'b0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else if (restart_i) begin
      mode_q <= fill_mode_i;
      fill_q <= fill_byte_i;
      cnt_q  <= '0;
    end else if (advance_i) begin
      cnt_q <= cnt_q + 8'(LANES);
    end
  end

  always_comb begin
    bytes_o = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      bytes_o[8*i +: 8] = mode_q ? (cnt_q + 8'(i)) : fill_q;
    end
  end

endmodule

// File: rtl/xgmii_frame_gen.sv
// XGMII frame generator: header, clamped payload, TERMINATE and inter-packet gap.
// Optional error injection port enabled by FRAME_GEN_ERR_INJECT_EN.
module xgmii_frame_gen
  import xgmii_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_payload_len,
  input  logic [7:0]            i_ipg,
  input  logic                  i_fill_mode,
  input  logic [7:0]            i_fill_byte,
`ifdef FRAME_GEN_ERR_INJECT_EN
  input  logic                  i_err_inject,
`endif
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam logic [LEN_WIDTH-1:0] LANES_L = LEN_WIDTH'(LANES);
  localparam logic [127:0]         HDR_EXT  = {64'h0, HDR_DATA};
  localparam logic [15:0]          HDR_CEXT = {8'h0, HDR_CTRL};

  state_t                state_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [7:0]            ipg_q;
  logic [8:0]            gap_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic                  busy_q;
  logic                  done_q;

  logic [LEN_WIDTH-1:0]  len_d;
  logic [8:0]            term_gap_d;
  logic [8:0]            ipg_gap_d;
  logic                  hdr_sel_d;
  logic                  accept_d;
  logic                  err_d;
  logic [DATA_WIDTH-1:0] hdr_data_d;
  logic [CTRL_WIDTH-1:0] hdr_ctrl_d;
  logic [DATA_WIDTH-1:0] pay_data_d;
  logic [CTRL_WIDTH-1:0] pay_ctrl_d;
  logic [DATA_WIDTH-1:0] src_bytes;

`ifdef FRAME_GEN_ERR_INJECT_EN
  assign err_d = i_err_inject;
`else
  assign err_d = 1'b0;
`endif

  assign accept_d = (state_q == IDLE) && i_start;

  xgmii_payload_src #(
    .LANES (LANES)
  ) u_src (
    .clk         (clk),
    .i_rst       (i_rst),
    .restart_i   (accept_d),
    .advance_i   (state_q == PAYLOAD),
    .fill_mode_i (i_fill_mode),
    .fill_byte_i (i_fill_byte),
    .bytes_o     (src_bytes)
  );

  always_comb begin
    if (i_payload_len < LEN_WIDTH'(MIN_LEN)) begin
      len_d = LEN_WIDTH'(MIN_LEN);
    end else if (i_payload_len > LEN_WIDTH'(MAX_LEN)) begin
      len_d = LEN_WIDTH'(MAX_LEN);
    end else begin
      len_d = i_payload_len;
    end
  end

  // Header spans at most two words, so PREAMBLE always emits the second (last) one.
  assign hdr_sel_d  = (state_q == PREAMBLE);
  assign hdr_data_d = HDR_EXT[DATA_WIDTH*int'(hdr_sel_d) +: DATA_WIDTH];
  assign hdr_ctrl_d = HDR_CEXT[CTRL_WIDTH*int'(hdr_sel_d) +: CTRL_WIDTH];

  // Idle lanes after TERMINATE in a partial word; only used when rem_q < LANES.
  assign term_gap_d = 9'(LANES - 1) - 9'(rem_q);
  assign ipg_gap_d  = gap_q + 9'(LANES);

  always_comb begin
    pay_data_d = '0;
    pay_ctrl_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (LEN_WIDTH'(i) < rem_q) begin
        pay_data_d[8*i +: 8] = err_d ? C_ERROR : src_bytes[8*i +: 8];
        pay_ctrl_d[i]        = err_d;
      end else if (LEN_WIDTH'(i) == rem_q) begin
        pay_data_d[8*i +: 8] = C_TERM;
        pay_ctrl_d[i]        = 1'b1;
      end else begin
        pay_data_d[8*i +: 8] = C_IDLE;
        pay_ctrl_d[i]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ipg_q   <= '0;
      gap_q   <= '0;
      data_q  <= {LANES{C_IDLE}};
      ctrl_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          data_q <= {LANES{C_IDLE}};
          ctrl_q <= '1;
          busy_q <= 1'b0;
          if (i_start) begin
            data_q  <= hdr_data_d;
            ctrl_q  <= hdr_ctrl_d;
            busy_q  <= 1'b1;
            rem_q   <= len_d;
            ipg_q   <= i_ipg;
            gap_q   <= '0;
            state_q <= (LANES == 8) ? PAYLOAD : PREAMBLE;
          end
        end
        PREAMBLE: begin
          data_q  <= hdr_data_d;
          ctrl_q  <= hdr_ctrl_d;
          state_q <= PAYLOAD;
        end
        PAYLOAD: begin
          data_q <= pay_data_d;
          ctrl_q <= pay_ctrl_d;
          if (rem_q < LANES_L) begin
            rem_q  <= '0;
            done_q <= 1'b1;
            gap_q  <= term_gap_d;
            if (term_gap_d >= {1'b0, ipg_q}) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= IPG;
            end
          end else if (rem_q == LANES_L) begin
            rem_q   <= '0;
            state_q <= TERM;
          end else begin
            rem_q <= rem_q - LANES_L;
          end
        end
        TERM: begin
          data_q <= {{(LANES-1){C_IDLE}}, C_TERM};
          ctrl_q <= '1;
          done_q <= 1'b1;
          gap_q  <= 9'(LANES - 1);
          if (9'(LANES - 1) >= {1'b0, ipg_q}) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= IPG;
          end
        end
        IPG: begin
          data_q <= {LANES{C_IDLE}};
          ctrl_q <= '1;
          gap_q  <= ipg_gap_d;
          if (ipg_gap_d >= {1'b0, ipg_q}) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_data = data_q;
  assign o_tx_ctrl = ctrl_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule
